serial_subtractor_64_bit: RTL and testbench
===========================================

// Module: serial_subtractor_64_bit
// PURPOSE
//  Multi-cycle 64-bit subtractor (a - b - bin), the inverse-direction companion of the 64-bit adder datapath.
//  Processes one 4-bit slice per clock, LSB slice first, through a single borrow slice, trading latency for area.
//  Valid/ready handshake on both input and output. Feeds the ALU compare/subtract path.
// PARAMETERS
//  WIDTH   64  operand width in bits; must be a multiple of SLICE
//  SLICE   4   bits processed per clock
//  NSLICE  WIDTH/SLICE (16), derived localparam, not overridable
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands present
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow out of MSB slice (1 = unsigned a < b + bin)
//  ovf        out  1      signed overflow
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, counter=0.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: in_ready=1. On edge with in_valid: capture a, b into shift regs, borrow<=bin, cnt<=0, -> RUN.
//  RUN: in_ready=0. Each edge: slice result {brw,d4} = a_sr[3:0] - b_sr[3:0] - borrow;
//   shift a_sr, b_sr right by SLICE; shift d4 into diff_sr from top; borrow<=brw; cnt<=cnt+1.
//   Capture sign bits a[63], b[63] at acceptance for ovf.
//   When cnt==NSLICE-1 on an edge: -> DONE, latch diff, bout=brw, ovf.
//  Latency: out_valid rises exactly NSLICE (16) edges after the accepting edge.
//  DONE: out_valid=1; diff/bout/ovf stable while out_valid && !out_ready.
//   On edge with out_ready: out_valid<=0, -> IDLE. in_ready=0 in DONE (no same-cycle reaccept).
//  ovf = (a[63] != b[63]) && (diff[63] != a[63]); bin does not change this definition.
//  in_valid outside IDLE is ignored; operands sampled only on acceptance edge, later changes have no effect.
//  diff/bout/ovf retain last result after handshake until next DONE overwrites them.
//  Wrap-around: a=0,b=0,bin=1 -> diff=all ones, bout=1 (legal, no error).
//  Reset mid-RUN or mid-DONE: abort immediately, outputs to reset values, result discarded.
//  No combinational path from in_valid or out_ready to any output.
// STRUCTURE
//  Shared package: state encoding (IDLE/RUN/DONE), WIDTH/SLICE defaults, NSLICE derivation.
//  Sub-module borrow_slice_4_bit: combinational 4-bit a - b - bin -> {bout, diff}, ripple-borrow internally.
//  Top holds FSM, counter ($clog2(NSLICE) bits), operand/result shift registers, ovf sign capture.
// TESTING
//  1 a=5, b=3, bin=0 -> after 16 edges diff=2, bout=0, ovf=0, out_valid=1.
//  2 a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0.
//  3 a=0x8000_0000_0000_0000, b=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1.
//  4 a=b=0x123, bin=1 -> diff=all ones, bout=1, ovf=0; out_ready low 5 cycles -> outputs held, in_ready=0.
//  5 rst_n low after 8 RUN cycles -> out_valid=0, in_ready=1; next op a=10,b=4 -> diff=6 in 16 edges.
//  6 back-to-back: in_valid held high, out_ready=1 -> each result correct, 18-edge accept-to-accept spacing.

Source files
------------

// File: rtl/serial_subtractor_64_bit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_64_bit_pkg
//  Purpose  : Shared constants for the serial 64-bit subtractor: default
//             operand/slice widths, derived slice count and FSM state codes.
//  Ports    : (package, none)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_64_bit_pkg;

    // Default datapath geometry
    localparam int c_WIDTH  = 64;
    localparam int c_SLICE  = 4;
    localparam int c_NSLICE = c_WIDTH / c_SLICE;

    // FSM state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

endpackage : serial_subtractor_64_bit_pkg
`default_nettype wire

// File: rtl/serial_subtractor_64_bit_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_64_bit_if
//  Purpose  : Operand/result handshake bundle for the serial subtractor.
//  Signals  : in_valid/in_ready  - operand handshake
//             a, b, bin          - minuend, subtrahend, borrow in
//             out_valid/out_ready- result handshake
//             diff, bout, ovf    - difference, borrow out, signed overflow
//  Modports : master - operand producer / result consumer
//             slave  - the subtractor
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_64_bit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

endinterface : serial_subtractor_64_bit_if
`default_nettype wire

// File: rtl/serial_subtractor_64_bit_borrow_slice_4_bit.sv
`default_nettype none
// ============================================================================
//  Module   : borrow_slice_4_bit
//  Purpose  : Combinational slice subtractor {o_bout, o_diff} = a - b - bin,
//             built as a ripple-borrow chain of full subtractors.
//  Ports    : i_a, i_b  [SLICE] - slice operands
//             i_bin     [1]     - borrow into bit 0
//             o_diff    [SLICE] - slice difference
//             o_bout    [1]     - borrow out of the top bit
//  Revision : 1.0 - initial release
// ============================================================================
module borrow_slice_4_bit #(
    parameter int SLICE = 4
) (
    input  wire logic [SLICE-1:0] i_a,
    input  wire logic [SLICE-1:0] i_b,
    input  wire logic             i_bin,
    output logic      [SLICE-1:0] o_diff,
    output logic                  o_bout
);

    logic [SLICE:0] w_brw;

    assign w_brw[0] = i_bin;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            // Full subtractor: borrow when a < b + borrow_in at this bit
            assign o_diff[gi]  = i_a[gi] ^ i_b[gi] ^ w_brw[gi];
            assign w_brw[gi+1] = (~i_a[gi] & i_b[gi])
                               | (~(i_a[gi] ^ i_b[gi]) & w_brw[gi]);
        end
    endgenerate

    assign o_bout = w_brw[SLICE];

endmodule : borrow_slice_4_bit
`default_nettype wire

// File: rtl/serial_subtractor_64_bit.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_64_bit
//  Purpose  : Multi-cycle WIDTH-bit subtractor (a - b - bin). One SLICE-bit
//             slice is processed per clock, LSB slice first, through a single
//             borrow slice. Valid/ready handshake on operands and result.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             s_bus  - slave side of serial_subtractor_64_bit_if
//                      (in_valid/in_ready, a, b, bin,
//                       out_valid/out_ready, diff, bout, ovf)
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor_64_bit
    import serial_subtractor_64_bit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int SLICE = c_SLICE
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    serial_subtractor_64_bit_if.slave    s_bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NSLICE - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_a_sr;
    logic [WIDTH-1:0]       r_b_sr;
    // Holds the slices already produced; the final slice is merged straight
    // into r_diff on the last edge, so this needs one slice less than WIDTH.
    logic [WIDTH-SLICE-1:0] r_diff_sr;
    logic                   r_brw;
    logic                   r_a_sign;
    logic                   r_b_sign;
    logic [WIDTH-1:0]       r_diff;
    logic                   r_bout;
    logic                   r_ovf;

    logic [SLICE-1:0]       w_slice_diff;
    logic                   w_slice_bout;

    // ------------------------------------------------------------------------
    // Single shared borrow slice working on the low slice of the shifters
    // ------------------------------------------------------------------------
    borrow_slice_4_bit #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a    (r_a_sr[SLICE-1:0]),
        .i_b    (r_b_sr[SLICE-1:0]),
        .i_bin  (r_brw),
        .o_diff (w_slice_diff),
        .o_bout (w_slice_bout)
    );

    // ------------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_diff_sr <= '0;
            r_brw     <= 1'b0;
            r_a_sign  <= 1'b0;
            r_b_sign  <= 1'b0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (s_bus.in_valid) begin
                        r_a_sr   <= s_bus.a;
                        r_b_sr   <= s_bus.b;
                        r_brw    <= s_bus.bin;
                        r_cnt    <= '0;
                        r_a_sign <= s_bus.a[WIDTH-1];
                        r_b_sign <= s_bus.b[WIDTH-1];
                        r_state  <= c_RUN;
                    end
                end

                c_RUN: begin
                    r_a_sr    <= r_a_sr >> SLICE;
                    r_b_sr    <= r_b_sr >> SLICE;
                    r_diff_sr <= {w_slice_diff, r_diff_sr[WIDTH-SLICE-1:SLICE]};
                    r_brw     <= w_slice_bout;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST_CNT) begin
                        r_diff  <= {w_slice_diff, r_diff_sr};
                        r_bout  <= w_slice_bout;
                        // Signed overflow: operand signs differ and the result
                        // sign departs from the minuend sign. The MSB of the
                        // final slice is the result sign bit.
                        r_ovf   <= (r_a_sign != r_b_sign) &&
                                   (w_slice_diff[SLICE-1] != r_a_sign);
                        r_state <= c_DONE;
                    end
                end

                c_DONE: begin
                    if (s_bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from registers: no combinational path from
    // in_valid or out_ready.
    assign s_bus.in_ready  = (r_state == c_IDLE);
    assign s_bus.out_valid = (r_state == c_DONE);
    assign s_bus.diff      = r_diff;
    assign s_bus.bout      = r_bout;
    assign s_bus.ovf       = r_ovf;

endmodule : serial_subtractor_64_bit
`default_nettype wire

// File: tb/tb_serial_subtractor_64_bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor_64_bit
//  Purpose  : Self-checking bench for serial_subtractor_64_bit. Expected
//             results are computed from a full-width reference subtraction
//             and queued when operands are driven; popped when out_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_64_bit;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_64_bit_if #(.WIDTH(W)) bus ();

    serial_subtractor_64_bit #(
        .WIDTH (W),
        .SLICE (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus)
    );

    // Reference model: 65-bit subtraction gives difference and borrow out.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        exp_t       e;
        r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        sb.push_back(e);
    endtask

    // Drive one operand set in IDLE; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_in_ready: got %b want 1", bus.in_ready);
        end
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        push_exp(a, b, bin);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Scramble operands: they must not influence the running operation
        bus.a   = {$urandom, $urandom};
        bus.b   = {$urandom, $urandom};
        bus.bin = 1'($urandom);
    endtask

    // Count edges after acceptance until out_valid seen (-1 on timeout).
    task automatic wait_out(output int lat);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.diff !== '0 || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: diff=%h bout=%b ovf=%b want 0/0/0", bus.diff, bus.bout, bus.ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] av[7];
        logic [W-1:0] bv[7];
        logic         cv[7];
        int           lat;
        exp_t         e;
        av[0] = 64'd5;                  bv[0] = 64'd3;  cv[0] = 1'b0;
        av[1] = 64'd0;                  bv[1] = 64'd1;  cv[1] = 1'b0;
        av[2] = 64'h8000_0000_0000_0000; bv[2] = 64'd1; cv[2] = 1'b0;
        av[3] = 64'h7FFF_FFFF_FFFF_FFFF; bv[3] = 64'hFFFF_FFFF_FFFF_FFFF; cv[3] = 1'b0;
        for (int i = 4; i < 7; i++) begin
            av[i] = {$urandom, $urandom};
            bv[i] = {$urandom, $urandom};
            cv[i] = 1'($urandom);
        end
        for (int i = 0; i < 7; i++) begin
            start_op(av[i], bv[i], cv[i]);
            wait_out(lat);
            checks++;
            if (lat != 16) begin
                failures++;
                $display("FAIL basic%0d_latency: got %0d want 16", i, lat);
            end
            e = sb.pop_front();
            checks++;
            if (bus.diff !== e.d) begin
                failures++;
                $display("FAIL basic%0d_diff: got %h want %h", i, bus.diff, e.d);
            end
            checks++;
            if (bus.bout !== e.bo || bus.ovf !== e.ov) begin
                failures++;
                $display("FAIL basic%0d_flags: bout=%b ovf=%b want %b/%b", i, bus.bout, bus.ovf, e.bo, e.ov);
            end
            release_out();
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL basic%0d_release: out_valid=%b in_ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int   lat;
        exp_t e;
        start_op(64'h123, 64'h123, 1'b1);
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 16 || bus.diff !== e.d || bus.bout !== e.bo || bus.ovf !== e.ov) begin
            failures++;
            $display("FAIL hold_result: lat=%0d diff=%h bout=%b ovf=%b want 16/%h/%b/%b",
                     lat, bus.diff, bus.bout, bus.ovf, e.d, e.bo, e.ov);
        end
        // Offer new operands while DONE: must be ignored
        bus.a        = 64'd1;
        bus.b        = 64'd2;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.diff !== e.d || bus.bout !== e.bo || bus.ovf !== e.ov) begin
                failures++;
                $display("FAIL hold_stall%0d: ov=%b ir=%b diff=%h bout=%b want 1/0/%h/%b",
                         i, bus.out_valid, bus.in_ready, bus.diff, bus.bout, e.d, e.bo);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== e.d) begin
            failures++;
            $display("FAIL hold_retain: ov=%b ir=%b diff=%h want 0/1/%h",
                     bus.out_valid, bus.in_ready, bus.diff, e.d);
        end
    endtask

    task automatic test_reset_abort();
        int   lat;
        exp_t e;
        start_op(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b1);
        repeat (8) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.diff !== '0 || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: ov=%b ir=%b diff=%h bout=%b ovf=%b want 0/1/0/0/0",
                     bus.out_valid, bus.in_ready, bus.diff, bus.bout, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(64'd10, 64'd4, 1'b0);
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if (lat != 16 || bus.diff !== e.d || bus.diff !== 64'd6) begin
            failures++;
            $display("FAIL abort_next: lat=%0d diff=%h want 16/%h", lat, bus.diff, e.d);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int           sent     = 0;
        int           got      = 0;
        int           last_acc = -1;
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                e = sb.pop_front();
                got++;
                checks++;
                if (bus.diff !== e.d || bus.bout !== e.bo || bus.ovf !== e.ov) begin
                    failures++;
                    $display("FAIL b2b%0d_result: diff=%h bout=%b ovf=%b want %h/%b/%b",
                             got, bus.diff, bus.bout, bus.ovf, e.d, e.bo, e.ov);
                end
            end
            if (bus.in_ready === 1'b1 && sent < 4) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 18) begin
                        failures++;
                        $display("FAIL b2b_spacing: got %0d want 18", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                c = 1'($urandom);
                bus.a        = a;
                bus.b        = b;
                bus.bin      = c;
                bus.in_valid = 1'b1;
                push_exp(a, b, c);
                sent++;
            end else if (sent == 4 && cyc == last_acc + 1) begin
                bus.in_valid = 1'b0;
            end
        end
        checks++;
        if (got != 4) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d results want 4", got);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_subtractor_64_bit
`default_nettype wire
